alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
Multi-cycle instruction sequencer for the 8-bit combinational ALU. It accepts one 16-bit instruction at a time over a valid/ready handshake and reads operands from an internal register file. It drives the ALU op/operand buses, waits a programmable settle time, then writes the ALU result back. It sits between the instruction source and the ALU; the ALU has no clock of its own.

Parameters:
NREG, 4, number of 8-bit registers in the internal file; power of 2, 2..16.
RW, 2, register index width = log2(NREG); instruction fields sized for RW=2.
ALU_LAT, 2, cycles alu_op/alu_a/alu_b held stable before alu_res is sampled; range 1..15.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  controller accepts instruction this cycle
instr  in  16  [15:13] opcode, [12] imm flag, [11:10] dst, [9:8] src_a, [7:0] imm8 or [1:0] src_b
alu_op  out  8  ALU op code; upper 5 bits always 0
alu_a  out  8  ALU operand A
alu_b  out  8  ALU operand B
alu_res  in  8  ALU result
done  out  1  one-cycle pulse: instruction retired
err  out  1  one-cycle pulse: illegal opcode retired without write
busy  out  1  state != IDLE
dbg_sel  in  RW  debug register read index
dbg_data  out  8  regfile[dbg_sel], combinational

Behaviour:
- Reset is sampled only on the rising clk edge. While rst_n=0: state=IDLE; all registers=0; alu_op=0, alu_a=0, alu_b=0; done=0, err=0, busy=0; instr_ready=0. First cycle after release: instr_ready=1.
- States: IDLE -> ISSUE -> WAIT -> WB -> IDLE.
- IDLE: instr_ready=1. On instr_valid&instr_ready, latch instr, go to ISSUE. instr_ready=0 in all other states; no skid buffer.
- ISSUE (1 cycle): decode and register ALU drive:
  - opcode 000 (load/mov): alu_op=0, alu_a = imm8 if imm else reg[src_a], alu_b=0. Forward op passes alu_a.
  - 001/010/011: alu_op=opcode, alu_a=reg[src_a], alu_b = imm8 if imm else reg[src_b].
  - 1xx: illegal (see Optional Feature); skip WAIT, go to WB.
  - Load wait counter with ALU_LAT-1.
- WAIT: hold alu_* stable; decrement counter; leave to WB when counter=0.
- WB: for legal opcodes, reg[dst] <= alu_res and done=1 for this cycle. For illegal opcodes, no write and err=1. Return to IDLE.
- ALU drive outputs keep their last value in IDLE; no return to 0.
- Latency: accept edge to done = ALU_LAT+2 cycles. Minimum initiation interval = ALU_LAT+3 cycles.
- Arithmetic: 8-bit, carry discarded, wraps modulo 256 (0xFF+0x01=0x00).
- dst equal to src: operands are read in ISSUE and the write happens in WB, so there is no hazard.
- dbg_data reflects the write on the cycle after WB.
- rst_n=0 mid-instruction: the instruction is abandoned, no done/err pulse, and registers are cleared.

Optional Feature:
ALU_SEQ_SUB_EN.
- Defined: opcode 100 = SUB. Drive alu_op=001 and alu_b = two's complement of the selected B operand (~b+1). Result = a-b modulo 256; done pulses.
- Undefined: opcode 100 is illegal like 101..111 (err pulse, no write).

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams (OP_FWD=3'b000, OP_ADD=3'b001, OP_AND=3'b010, OP_OR=3'b011, OP_SUB=3'b100)
  - state encoding (IDLE, ISSUE, WAIT, WB)
  - instruction field bit positions
- One sub-module, alu_seq_regfile: NREG x 8 register file, sync write, two async read ports plus the debug port, sync clear on rst_n=0.

Test Plan:
- Reset then first instruction: rst_n low 3 cycles -> outputs 0. Issue {000,1,dst=1,imm=0x5A} -> done at accept+ALU_LAT+2; dbg_sel=1 gives 0x5A.
- ADD wrap: r1=0xFF, r2=0x01; ADD r3=r1+r2 -> r3=0x00, alu_op=0x01 held ALU_LAT cycles.
- AND/OR immediates: r0=0xF0; AND imm 0x3C -> 0x30; OR imm 0x0F into r1 -> 0xFF.
- Backpressure: hold instr_valid=1 with 3 queued instructions -> instr_ready high only in IDLE; each instruction accepted exactly once and retired in order.
- Illegal opcode 111 (and 100 without ALU_SEQ_SUB_EN) -> err pulse, no done, regfile unchanged. With ALU_SEQ_SUB_EN, 0x10-0x20 -> 0xF0.
- Reset mid-WAIT: assert rst_n=0 during WAIT -> no done pulse; all registers 0; instr_ready=1 the cycle after release.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM states and instruction field positions for the ALU sequencer
package alu_seq_pkg;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB
  } state_t;

  // instruction layout: [15:13] opcode, [12] imm, [11:10] dst, [9:8] src_a, [7:0] imm8 / [1:0] src_b
  localparam int F_OPC_LO  = 13;
  localparam int F_IMM     = 12;
  localparam int F_DST_LO  = 10;
  localparam int F_SRCA_LO = 8;
  localparam int F_SRCB_LO = 0;
  localparam int F_IMM8_LO = 0;

endpackage

// File: rtl/alu_seq_regfile.sv
// rtl/alu_seq_regfile.sv - NREG x 8 register file, sync write/clear, two async read ports plus debug port
module alu_seq_regfile #(
  parameter int NREG = 4,
  parameter int RW   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [RW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [RW-1:0] raddr_a,
  output logic [7:0]    rdata_a,
  input  logic [RW-1:0] raddr_b,
  output logic [7:0]    rdata_b,
  input  logic [RW-1:0] dbg_sel,
  output logic [7:0]    dbg_data
);

  logic [7:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-cycle sequencer driving an external combinational 8-bit ALU
// Optional SUB opcode (100) enabled by defining ALU_SEQ_SUB_EN.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int NREG    = 4,
  parameter int RW      = 2,
  parameter int ALU_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  output logic [7:0]    alu_op,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  input  logic [7:0]    alu_res,
  output logic          done,
  output logic          err,
  output logic          busy,
  input  logic [RW-1:0] dbg_sel,
  output logic [7:0]    dbg_data
);

  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);

  state_t        state, state_nx;
  logic [15:0]   instr_q;
  logic [3:0]    cnt;
  logic [2:0]    opc;
  logic          imm, legal, we;
  logic [RW-1:0] dst, src_a, src_b;
  logic [7:0]    imm8, rd_a, rd_b, b_sel;

  assign opc   = instr_q[F_OPC_LO +: 3];
  assign imm   = instr_q[F_IMM];
  assign dst   = instr_q[F_DST_LO +: RW];
  assign src_a = instr_q[F_SRCA_LO +: RW];
  assign src_b = instr_q[F_SRCB_LO +: RW];
  assign imm8  = instr_q[F_IMM8_LO +: 8];
  assign b_sel = imm ? imm8 : rd_b;

`ifdef ALU_SEQ_SUB_EN
  assign legal = !opc[2] || (opc == OP_SUB);
`else
  assign legal = !opc[2];
`endif

  assign we          = (state == S_WB) && legal;
  assign instr_ready = rst_n && (state == S_IDLE);
  assign busy        = (state != S_IDLE);

  alu_seq_regfile #(.NREG(NREG), .RW(RW)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (dst),
    .wdata    (alu_res),
    .raddr_a  (src_a),
    .rdata_a  (rd_a),
    .raddr_b  (src_b),
    .rdata_b  (rd_b),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (instr_valid && instr_ready) state_nx = S_ISSUE;
      S_ISSUE: state_nx = legal ? S_WAIT : S_WB;
      S_WAIT:  if (cnt == 4'd0) state_nx = S_WB;
      S_WB:    state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ALU drive is registered in ISSUE and held through WAIT/WB and the following idle time
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q <= '0;
      cnt     <= '0;
      alu_op  <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= we;
      err  <= (state == S_WB) && !legal;
      if (state == S_IDLE && instr_valid) instr_q <= instr;
      if (state == S_WAIT) cnt <= cnt - 4'd1;
      if (state == S_ISSUE) begin
        cnt <= LAT_INIT;
        case (opc)
          OP_FWD: begin
            alu_op <= {5'b0, OP_FWD};
            alu_a  <= imm ? imm8 : rd_a;
            alu_b  <= '0;
          end
          OP_ADD, OP_AND, OP_OR: begin
            alu_op <= {5'b0, opc};
            alu_a  <= rd_a;
            alu_b  <= b_sel;
          end
`ifdef ALU_SEQ_SUB_EN
          OP_SUB: begin
            alu_op <= {5'b0, OP_ADD};
            alu_a  <= rd_a;
            alu_b  <= ~b_sel + 8'd1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed self-checking bench for alu_seq_ctrl with a behavioural ALU
module tb_alu_seq_ctrl;

  localparam int NREG    = 4;
  localparam int RW      = 2;
  localparam int ALU_LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [15:0]   instr = '0;
  logic [7:0]    alu_op, alu_a, alu_b, alu_res;
  logic          done, err, busy;
  logic [RW-1:0] dbg_sel = '0;
  logic [7:0]    dbg_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] op_first, op_last;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.NREG(NREG), .RW(RW), .ALU_LAT(ALU_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_res     (alu_res),
    .done        (done),
    .err         (err),
    .busy        (busy),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  always_comb begin
    case (alu_op)
      8'd0:    alu_res = alu_a;
      8'd1:    alu_res = alu_a + alu_b;
      8'd2:    alu_res = alu_a & alu_b;
      8'd3:    alu_res = alu_a | alu_b;
      default: alu_res = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [2:0] opc, input logic imm, input logic [1:0] dst,
                                     input logic [1:0] sa, input logic [7:0] lo);
    return {opc, imm, dst, sa, lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] r, output logic [7:0] v);
    dbg_sel = r;
    #1;
    v = dbg_data;
  endtask

  task automatic exec(input string tag, input logic [15:0] ins, input logic legal);
    int t;
    int cyc;
    t = 0;
    instr = ins;
    instr_valid = 1'b1;
    while (!instr_ready && t < 50) begin
      tick();
      t++;
    end
    tick();
    instr_valid = 1'b0;
    cyc = 0;
    op_first = '0;
    op_last = '0;
    while (!done && !err && cyc < 40) begin
      tick();
      cyc++;
      if (cyc == 1) op_first = alu_op;
      if (cyc == ALU_LAT + 1) op_last = alu_op;
    end
    check({tag, " latency"}, 16'(cyc), legal ? 16'(ALU_LAT + 2) : 16'd2);
    check({tag, " done"}, {15'b0, done}, {15'b0, legal});
    check({tag, " err"}, {15'b0, err}, {15'b0, !legal});
  endtask

  initial begin
    logic [7:0]  v;
    logic [15:0] q [3];
    int          k, ndone, bad, edges, npulse;
    logic        acc;

    repeat (3) tick();
    check("rst instr_ready", instr_ready, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst err", err, 1'b0);
    check("rst alu_op", alu_op, 8'h00);
    check("rst alu_a", alu_a, 8'h00);
    check("rst alu_b", alu_b, 8'h00);
    rst_n = 1'b1;
    #1;
    check("release instr_ready", instr_ready, 1'b1);

    exec("ld r1 5A", mk(3'b000, 1'b1, 2'd1, 2'd0, 8'h5A), 1'b1);
    rd(2'd1, v);
    check("r1 after load", v, 8'h5A);
    tick();
    check("done one-cycle pulse", done, 1'b0);

    exec("ld r1 FF", mk(3'b000, 1'b1, 2'd1, 2'd0, 8'hFF), 1'b1);
    exec("ld r2 01", mk(3'b000, 1'b1, 2'd2, 2'd0, 8'h01), 1'b1);
    exec("add r3", mk(3'b001, 1'b0, 2'd3, 2'd1, 8'h02), 1'b1);
    rd(2'd3, v);
    check("add wrap r3", v, 8'h00);
    check("add alu_op at issue", op_first, 8'h01);
    check("add alu_op before wb", op_last, 8'h01);
    check("add alu_a held", alu_a, 8'hFF);
    check("add alu_b held", alu_b, 8'h01);

    exec("ld r0 F0", mk(3'b000, 1'b1, 2'd0, 2'd0, 8'hF0), 1'b1);
    exec("and imm", mk(3'b010, 1'b1, 2'd2, 2'd0, 8'h3C), 1'b1);
    exec("or imm", mk(3'b011, 1'b1, 2'd1, 2'd0, 8'h0F), 1'b1);
    rd(2'd2, v);
    check("and r2", v, 8'h30);
    rd(2'd1, v);
    check("or r1", v, 8'hFF);

    q[0] = mk(3'b000, 1'b1, 2'd0, 2'd0, 8'h11);
    q[1] = mk(3'b000, 1'b1, 2'd1, 2'd0, 8'h22);
    q[2] = mk(3'b001, 1'b0, 2'd2, 2'd0, 8'h01);
    k = 0; ndone = 0; bad = 0; edges = 0;
    instr = q[0];
    instr_valid = 1'b1;
    while (ndone < 3 && edges < 60) begin
      if (instr_ready && busy) bad++;
      acc = instr_ready && instr_valid;
      tick();
      edges++;
      if (done) ndone++;
      if (acc) begin
        k++;
        if (k < 3) instr = q[k];
        else instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    check("bp accepts", 16'(k), 16'd3);
    check("bp retires", 16'(ndone), 16'd3);
    check("bp ready while busy", 16'(bad), 16'd0);
    check("bp total cycles", 16'(edges), 16'(3 * (ALU_LAT + 3)));
    rd(2'd2, v);
    check("bp in-order result", v, 8'h33);

    exec("illegal 111", mk(3'b111, 1'b1, 2'd1, 2'd0, 8'h77), 1'b0);
    rd(2'd1, v);
    check("illegal no write", v, 8'h22);
    tick();
    check("err one-cycle pulse", err, 1'b0);

`ifdef ALU_SEQ_SUB_EN
    exec("ld r0 10", mk(3'b000, 1'b1, 2'd0, 2'd0, 8'h10), 1'b1);
    exec("ld r1 20", mk(3'b000, 1'b1, 2'd1, 2'd0, 8'h20), 1'b1);
    exec("sub", mk(3'b100, 1'b0, 2'd2, 2'd0, 8'h01), 1'b1);
    rd(2'd2, v);
    check("sub r2", v, 8'hF0);
`else
    exec("illegal 100", mk(3'b100, 1'b1, 2'd1, 2'd0, 8'h55), 1'b0);
    rd(2'd1, v);
    check("illegal 100 no write", v, 8'h22);
`endif

    instr = mk(3'b001, 1'b0, 2'd3, 2'd0, 8'h01);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    check("mid busy before reset", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    check("mid rst done", done, 1'b0);
    check("mid rst busy", busy, 1'b0);
    check("mid rst instr_ready", instr_ready, 1'b0);
    for (int r = 0; r < NREG; r++) begin
      rd(2'(r), v);
      check("mid rst reg cleared", v, 8'h00);
    end
    rst_n = 1'b1;
    #1;
    check("mid release instr_ready", instr_ready, 1'b1);
    npulse = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done || err) npulse++;
    end
    check("mid no retire pulse", 16'(npulse), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
